// File: rtl/spi_arb_pkg.sv
// Shared types and field widths for the SPI bus arbiter.
package spi_arb_pkg;

  localparam int SPI_ADDR_W = 16;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_NB_W   = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    WAIT  = S_WAIT,
    RESP  = S_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first asserted request after last_grant.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    // Walk last_grant+1 .. last_grant+NUM_REQ so the previous winner is checked last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin sharing of one spi_master port among NUM_REQ requesters,
// one transaction per grant, with a completion timeout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_core_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*SPI_ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]             req_rnw_i,
  input  logic [NUM_REQ*SPI_NB_W-1:0]    req_num_bytes_i,
  input  logic [NUM_REQ*SPI_DATA_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic [SPI_DATA_W-1:0]          rdata_byte1_o,
  output logic [SPI_DATA_W-1:0]          rdata_byte2_o,
  output logic                           spi_start_o,
  output logic [SPI_ADDR_W-1:0]          spi_address_o,
  output logic                           spi_read_not_write_o,
  output logic [SPI_NB_W-1:0]            spi_num_bytes_o,
  output logic [SPI_DATA_W-1:0]          spi_wdata_o,
  input  logic                           spi_done_i,
  input  logic                           spi_busy_i,
  input  logic [SPI_DATA_W-1:0]          spi_rdata_byte1_i,
  input  logic [SPI_DATA_W-1:0]          spi_rdata_byte2_i,
  output logic [1:0]                     state_o
);

  // Handshake: req_i is a level held until done_o for that requester; done_o is a
  // single-cycle pulse. Toward the master, spi_start_o is a one-cycle pulse and
  // spi_done_i is accepted only in WAIT.

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t       state_q;
  logic [IDX_W-1:0] winner_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_i),
    .last_grant (last_grant_q),
    .winner     (pick),
    .valid      (pick_valid)
  );

  assign timeout_hit = TIMEOUT_EN && (cnt_q == TERM_CNT);
  assign gnt_o       = (state_q != IDLE) ? (NUM_REQ'(1) << winner_q) : '0;
  assign state_o     = state_q;

  always_ff @(posedge clk_core_i) begin
    if (rst_i) begin
      state_q              <= IDLE;
      winner_q             <= '0;
      last_grant_q         <= IDX_W'(NUM_REQ - 1);
      cnt_q                <= '0;
      done_o               <= '0;
      err_o                <= 1'b0;
      rdata_byte1_o        <= '0;
      rdata_byte2_o        <= '0;
      spi_start_o          <= 1'b0;
      spi_address_o        <= '0;
      spi_read_not_write_o <= 1'b0;
      spi_num_bytes_o      <= '0;
      spi_wdata_o          <= '0;
    end else begin
      spi_start_o <= 1'b0;
      done_o      <= '0;
      err_o       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid && !spi_busy_i) begin
            state_q              <= ISSUE;
            winner_q             <= pick;
            last_grant_q         <= pick;
            spi_start_o          <= 1'b1;
            spi_address_o        <= req_addr_i[int'(pick)*SPI_ADDR_W +: SPI_ADDR_W];
            spi_read_not_write_o <= req_rnw_i[pick];
            spi_num_bytes_o      <= req_num_bytes_i[int'(pick)*SPI_NB_W +: SPI_NB_W];
            spi_wdata_o          <= req_wdata_i[int'(pick)*SPI_DATA_W +: SPI_DATA_W];
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A done on the terminal count still counts as success.
          if (spi_done_i) begin
            state_q       <= RESP;
            done_o        <= NUM_REQ'(1) << winner_q;
            rdata_byte1_o <= spi_rdata_byte1_i;
            rdata_byte2_o <= spi_rdata_byte2_i;
          end else if (timeout_hit) begin
            state_q       <= RESP;
            done_o        <= NUM_REQ'(1) << winner_q;
            err_o         <= 1'b1;
            rdata_byte1_o <= '0;
            rdata_byte2_o <= '0;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: single, contention, busy, timeout,
// done-on-terminal-count and mid-transaction reset.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TMO     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_rnw = '0;
  logic [3:0]  req_nb = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  gnt, done;
  logic        err;
  logic [7:0]  rd1, rd2;
  logic        spi_start, spi_rnw;
  logic [15:0] spi_addr;
  logic [1:0]  spi_nb;
  logic [7:0]  spi_wdata;
  logic        spi_done = 1'b0;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_rd1 = '0, spi_rd2 = '0;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  spi_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_core_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr),
    .req_rnw_i(req_rnw), .req_num_bytes_i(req_nb), .req_wdata_i(req_wdata),
    .gnt_o(gnt), .done_o(done), .err_o(err),
    .rdata_byte1_o(rd1), .rdata_byte2_o(rd2),
    .spi_start_o(spi_start), .spi_address_o(spi_addr),
    .spi_read_not_write_o(spi_rnw), .spi_num_bytes_o(spi_nb), .spi_wdata_o(spi_wdata),
    .spi_done_i(spi_done), .spi_busy_i(spi_busy),
    .spi_rdata_byte1_i(spi_rd1), .spi_rdata_byte2_i(spi_rd2),
    .state_o(state)
  );

  always @(negedge clk) if (spi_start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max_cycles);
    for (int n = 0; n < max_cycles && !spi_start; n++) step();
    check("start_seen", {31'd0, spi_start}, 32'd1);
  endtask

  // Master model: done pulse lat cycles after the start cycle; returns in RESP.
  task automatic master_respond(input int lat, input logic [7:0] b1, input logic [7:0] b2);
    repeat (lat) step();
    spi_done = 1'b1; spi_rd1 = b1; spi_rd2 = b2;
    step();
    spi_done = 1'b0; spi_rd1 = '0; spi_rd2 = '0;
  endtask

  initial begin
    logic [1:0] g;
    logic [15:0] exp_addr;
    int s0;
    req_addr  = {16'hBEEF, 16'h0012};
    req_rnw   = 2'b01;
    req_nb    = {2'd2, 2'd1};
    req_wdata = {8'h5A, 8'h00};

    // reset state
    repeat (2) step();
    rst = 1'b0;
    check("rst_state", state, S_IDLE);
    check("rst_gnt", gnt, 0);
    check("rst_outs", {done, err, spi_start, spi_addr, rd1, rd2}, 0);

    // single read from requester 0
    req = 2'b01;
    step();
    check("single_start", spi_start, 1);
    check("single_gnt", gnt, 2'b01);
    check("single_addr", spi_addr, 16'h0012);
    check("single_fields", {spi_rnw, spi_nb}, {1'b1, 2'd1});
    step();
    check("single_start_1cyc", spi_start, 0);
    check("single_wait", state, S_WAIT);
    master_respond(5, 8'hA5, 8'h00);
    check("single_done", done, 2'b01);
    check("single_err", err, 0);
    check("single_rd1", rd1, 8'hA5);
    req = 2'b00;
    step();
    check("single_done_pulse", done, 0);
    check("single_gnt_clear", gnt, 0);

    // contention: both held; last winner was 0 so order is 1,0,1,0
    exp_q = '{2'd1, 2'd0, 2'd1, 2'd0};
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_start(20);
      g = exp_q.pop_front();
      exp_addr = (g == 2'd1) ? 16'hBEEF : 16'h0012;
      check("cont_gnt", gnt, 2'b01 << g);
      check("cont_addr", spi_addr, exp_addr);
      master_respond(2, 8'h10 + 8'(t), 8'h20 + 8'(t));
      check("cont_done", done, 2'b01 << g);
      check("cont_rd2", rd2, 8'h20 + 8'(t));
      if (t == 3) req = 2'b00;
      step();
    end

    // busy blocks issue
    spi_busy = 1'b1;
    req = 2'b10;
    s0 = start_cnt;
    repeat (5) step();
    check("busy_no_start", s0 == start_cnt, 1);
    check("busy_idle", state, S_IDLE);
    spi_busy = 1'b0;
    step();
    check("busy_start", spi_start, 1);
    check("busy_gnt", gnt, 2'b10);
    check("busy_wdata", {spi_rnw, spi_nb, spi_wdata}, {1'b0, 2'd2, 8'h5A});
    master_respond(2, 8'h77, 8'h88);
    check("busy_done", done, 2'b10);
    req = 2'b00;
    step();

    // timeout: master silent, RESP follows the 8th WAIT cycle
    req = 2'b01;
    step();
    check("tmo_gnt", gnt, 2'b01);
    repeat (8) step();
    check("tmo_still_wait", {state, done}, {S_WAIT, 2'b00});
    step();
    check("tmo_done", done, 2'b01);
    check("tmo_err", err, 1);
    check("tmo_rdata", {rd1, rd2}, 16'h0000);
    req = 2'b00;
    step();
    check("tmo_err_pulse", err, 0);

    // done on the terminal count wins over the timeout
    req = 2'b10;
    step();
    check("coin_gnt", gnt, 2'b10);
    master_respond(8, 8'h3C, 8'hC3);
    check("coin_done", done, 2'b10);
    check("coin_err", err, 0);
    check("coin_rdata", {rd1, rd2}, 16'h3CC3);
    req = 2'b00;
    step();

    // reset during WAIT, then requester 0 wins first
    req = 2'b11;
    step();
    check("rstw_start", spi_start, 1);
    repeat (2) step();
    check("rstw_in_wait", state, S_WAIT);
    rst = 1'b1;
    step();
    check("rstw_state", state, S_IDLE);
    check("rstw_gnt", gnt, 0);
    check("rstw_outs", {done, err, spi_start, rd1, rd2}, 0);
    check("rstw_fields", {spi_addr, spi_rnw, spi_nb, spi_wdata}, 0);
    rst = 1'b0;
    step();
    check("rstw_first_gnt", gnt, 2'b01);
    master_respond(1, 8'h01, 8'h02);
    check("rstw_done", done, 2'b01);
    req = 2'b00;
    step();

    check("start_total", start_cnt, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
